// File: rtl/nec_ir_transmitter.sv
// nec_ir_transmitter: NEC IR frame generator (lead, 32 pulse-distance bits, stop, gap)
// with a carrier-modulated LED drive and a valid/ready request port.
module nec_ir_transmitter #(
    parameter int TICK_CYCLES  = 22500,
    parameter int CARRIER_HALF = 526,
    parameter int GAP_TICKS    = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_addr,
    input  logic [7:0] tx_data,
    input  logic       tx_repeat,
    output logic       tx_done,
    output logic       ir_env,
    output logic       ir_out
);
    localparam int MAXT = GAP_TICKS > 16 ? GAP_TICKS : 16;
    localparam int TW   = $clog2(MAXT + 1);
    localparam int PW   = $clog2(TICK_CYCLES);
    localparam int CW   = $clog2(CARRIER_HALF + 1);

    typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP} state_t;

    state_t          r_state, w_next;
    logic [PW-1:0]   r_pre;
    logic [TW-1:0]   r_ticks, w_last;
    logic [CW-1:0]   r_car;
    logic [5:0]      r_bit;
    logic [31:0]     r_shift;
    logic            r_rep, r_env, r_ph, r_done;
    logic            w_accept, w_tick, w_seg_end, w_mark_next, w_car_wrap;

    assign tx_ready    = r_state == IDLE;
    assign tx_done     = r_done;
    assign ir_env      = r_env;
    assign ir_out      = r_env & r_ph;
    assign w_accept    = tx_valid && tx_ready;
    assign w_tick      = r_pre == PW'(TICK_CYCLES - 1);
    assign w_car_wrap  = r_car == CW'(CARRIER_HALF - 1);
    // last tick index of the current segment (segment length minus one)
    assign w_last      = r_state == LEAD_MARK  ? TW'(15) :
                         r_state == LEAD_SPACE ? (r_rep ? TW'(3) : TW'(7)) :
                         r_state == BIT_SPACE  ? (r_shift[0] ? TW'(2) : TW'(0)) :
                         r_state == GAP        ? TW'(GAP_TICKS - 1) : TW'(0);
    assign w_seg_end   = w_tick && r_ticks == w_last;
    assign w_mark_next = w_next == LEAD_MARK || w_next == BIT_MARK || w_next == STOP_MARK;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       w_next = w_accept ? LEAD_MARK : IDLE;
            LEAD_MARK:  w_next = w_seg_end ? LEAD_SPACE : LEAD_MARK;
            LEAD_SPACE: w_next = w_seg_end ? (r_rep ? STOP_MARK : BIT_MARK) : LEAD_SPACE;
            BIT_MARK:   w_next = w_seg_end ? BIT_SPACE : BIT_MARK;
            BIT_SPACE:  w_next = w_seg_end ? (r_bit == 6'd31 ? STOP_MARK : BIT_MARK) : BIT_SPACE;
            STOP_MARK:  w_next = w_seg_end ? GAP : STOP_MARK;
            GAP:        w_next = w_seg_end ? IDLE : GAP;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pre   <= '0;
            r_ticks <= '0;
            r_car   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_rep   <= 1'b0;
            r_env   <= 1'b0;
            r_ph    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_env   <= w_mark_next;
            r_done  <= r_state == GAP && w_seg_end;
            if (w_accept) begin
                r_shift <= {~tx_data, tx_data, ~tx_addr, tx_addr};
                r_rep   <= tx_repeat;
                r_pre   <= '0;
                r_ticks <= '0;
                r_bit   <= '0;
            end else if (r_state != IDLE) begin
                r_pre   <= w_tick ? '0 : r_pre + 1'b1;
                r_ticks <= w_seg_end ? '0 : (w_tick ? r_ticks + 1'b1 : r_ticks);
                if (r_state == BIT_SPACE && w_seg_end) begin
                    r_shift <= r_shift >> 1;
                    r_bit   <= r_bit + 1'b1;
                end
            end
            // every mark begins with a fresh high carrier half-period
            if (w_mark_next && w_next != r_state) begin
                r_car <= '0;
                r_ph  <= 1'b1;
            end else if (r_env) begin
                r_car <= w_car_wrap ? '0 : r_car + 1'b1;
                r_ph  <= w_car_wrap ? ~r_ph : r_ph;
            end else begin
                r_car <= '0;
                r_ph  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_nec_ir_transmitter.sv
// tb_nec_ir_transmitter: table-driven frames plus back-to-back and reset-abort
// sequences; a negedge monitor decodes envelopes and checks them against a scoreboard.
module tb_nec_ir_transmitter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_addr;
    logic [7:0] tx_data;
    logic       tx_repeat;
    logic       tx_done;
    logic       ir_env;
    logic       ir_out;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic       r;
        int         span;
    } exp_t;

    exp_t exp_q[$];
    exp_t vecs[6];
    int   n_checks = 0;
    int   n_fail = 0;
    int   frames_done = 0;

    nec_ir_transmitter #(.TICK_CYCLES(4), .CARRIER_HALF(1), .GAP_TICKS(2)) dut (
        .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_addr(tx_addr), .tx_data(tx_data), .tx_repeat(tx_repeat),
        .tx_done(tx_done), .ir_env(ir_env), .ir_out(ir_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: run lengths of the envelope from first mark to tx_done
    initial begin
        int         runs[$];
        int         cyc, last_high, run_len, car_err, ready_hi, bad;
        logic       prev_env, in_frame;
        logic [31:0] w;
        exp_t       e;
        in_frame = 1'b0;
        prev_env = 1'b0;
        cyc = 0; last_high = 0; run_len = 0; car_err = 0; ready_hi = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
                continue;
            end
            if (!in_frame && ir_env) begin
                in_frame = 1'b1;
                runs.delete();
                cyc = 0; run_len = 0; car_err = 0; ready_hi = 0; last_high = 0;
                prev_env = 1'b1;
            end else if (in_frame) begin
                cyc++;
                if (ir_env != prev_env) begin
                    runs.push_back(run_len);
                    run_len = 0;
                end
            end
            if (in_frame) begin
                if (ir_env) begin
                    last_high = cyc;
                    if (ir_out != (run_len % 2 == 0)) car_err++;
                end else if (ir_out) car_err++;
                run_len++;
                if (tx_ready && !tx_done) ready_hi++;
                prev_env = ir_env;
            end
            if (tx_done) begin
                frames_done++;
                chk("ready_at_done", tx_ready, 1);
                if (!in_frame || exp_q.size() == 0) chk("done_without_frame", 0, 1);
                else begin
                    e = exp_q.pop_front();
                    chk("lead_mark", runs.size() > 0 ? runs[0] : -1, 64);
                    chk("lead_space", runs.size() > 1 ? runs[1] : -1, e.r ? 16 : 32);
                    chk("span", last_high + 1, e.span);
                    chk("gap_to_done", cyc - last_high - 1, 8);
                    chk("carrier_errs", car_err, 0);
                    chk("ready_in_frame", ready_hi, 0);
                    if (e.r) begin
                        chk("repeat_runs", runs.size(), 3);
                        chk("repeat_stop", runs.size() > 2 ? runs[2] : -1, 4);
                    end else begin
                        chk("normal_runs", runs.size(), 67);
                        w = '0;
                        bad = 0;
                        if (runs.size() == 67) begin
                            for (int i = 0; i < 32; i++) begin
                                if (runs[2 + 2 * i] != 4) bad++;
                                if (runs[3 + 2 * i] != 4 && runs[3 + 2 * i] != 12) bad++;
                                w[i] = runs[3 + 2 * i] == 12;
                            end
                            if (runs[66] != 4) bad++;
                        end
                        chk("bit_widths", bad, 0);
                        chk("word", w, {~e.d, e.d, ~e.a, e.a});
                    end
                end
                in_frame = 1'b0;
            end
        end
    end

    task automatic wait_done();
        int s = frames_done;
        int i = 0;
        while (frames_done == s && i < 1500) begin
            @(negedge clk);
            i++;
        end
        chk("frame_done_in_time", frames_done != s, 1);
    endtask

    task automatic send(input exp_t v);
        @(negedge clk);
        tx_addr = v.a; tx_data = v.d; tx_repeat = v.r; tx_valid = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_addr = ~v.a; tx_data = ~v.d; tx_repeat = ~v.r;
        wait_done();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        exp_t v;
        vecs[0] = '{8'h00, 8'hFF, 1'b0, 484};
        vecs[1] = '{8'hA5, 8'h3C, 1'b0, 484};
        vecs[2] = '{8'hFF, 8'h00, 1'b0, 484};
        vecs[3] = '{8'h12, 8'h34, 1'b1, 84};
        vecs[4] = '{8'($urandom), 8'($urandom), 1'b0, 484};
        vecs[5] = '{8'($urandom), 8'($urandom), 1'b0, 484};
        rst_n = 1'b0; tx_valid = 1'b0; tx_addr = '0; tx_data = '0; tx_repeat = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", tx_ready, 1);
        chk("reset_done", tx_done, 0);
        chk("reset_env", ir_env, 0);
        chk("reset_out", ir_out, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) send(vecs[i]);

        // back-to-back: tx_valid held, fields change mid-frame
        @(negedge clk);
        tx_addr = 8'hA1; tx_data = 8'hB2; tx_repeat = 1'b0; tx_valid = 1'b1;
        exp_q.push_back('{8'hA1, 8'hB2, 1'b0, 484});
        @(negedge clk);
        chk("b2b_ready_low", tx_ready, 0);
        tx_addr = 8'hC3; tx_data = 8'hD4; tx_repeat = 1'b1;
        exp_q.push_back('{8'hC3, 8'hD4, 1'b1, 84});
        for (int i = 0; i < 1500 && !tx_done; i++) @(negedge clk);
        chk("b2b_first_done", tx_done, 1);
        @(negedge clk);
        chk("b2b_second_start", ir_env, 1);
        chk("b2b_second_busy", tx_ready, 0);
        tx_valid = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        // reset during a data-bit space aborts the frame silently
        @(negedge clk);
        tx_addr = 8'h5A; tx_data = 8'hC3; tx_repeat = 1'b0; tx_valid = 1'b1;
        exp_q.push_back('{8'h5A, 8'hC3, 1'b0, 484});
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (102) @(negedge clk);
        chk("abort_in_space_env", ir_env, 0);
        chk("abort_in_space_busy", tx_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_env", ir_env, 0);
        chk("abort_out", ir_out, 0);
        chk("abort_ready", tx_ready, 1);
        chk("abort_done", tx_done, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = frames_done;
        repeat (600) @(negedge clk);
        chk("abort_no_done", frames_done, n);
        v = '{8'h96, 8'h69, 1'b0, 484};
        send(v);
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
